switch_mcu_fetch: RTL and testbench
===================================

# switch_mcu_fetch

Instruction fetch and sequencing stage of the switch MCU core, directly upstream of the instruction decoder. It owns the program counter, reads each 32-bit instruction from instruction memory over a req/ack handshake, and presents it with the per-instruction cycle counter that drives the decoder and execute stages. It also applies branch/jump redirects from execute and holds the counter on execute stalls.

## Interface
- RESET_PC, 32'h0000_0000: first fetch address after reset; bits [1:0] must be 0.
- INST_CYCLES, 4: execute cycles per instruction; legal range 2..15.

- in_clk  input  1  core clock; all state updates on the rising edge.
- in_rst  input  1  reset, asynchronous, active-low.
- out_imem_req  output  1  instruction read request, registered.
- out_imem_addr  output  32  word-aligned read address; stable while out_imem_req=1.
- in_imem_ack  input  1  read completes this cycle; honoured only when out_imem_req=1.
- in_imem_rdata  input  32  instruction word; valid when in_imem_ack=1.
- in_stall  input  1  execute hold; freezes the cycle counter in EXEC.
- in_redirect  input  1  execute requests a control transfer for the current instruction.
- in_redirect_pc  input  32  redirect target; valid with in_redirect.
- out_inst  output  32  current instruction word; the decoder input.
- out_pc  output  32  address of out_inst.
- out_cycle_cnt  output  4  execute cycle index 0..INST_CYCLES-1; 4'hF while fetching.
- out_inst_done  output  1  one-cycle pulse on the last execute cycle of an instruction.

## Operation
- The block has two states:
  - FETCH: out_imem_req=1 and out_imem_addr=pc. out_cycle_cnt=4'hF, so the decoder never latches in this state.
  - EXEC: out_cycle_cnt counts from 0.
- Reset values:
  - state=FETCH, pc=RESET_PC.
  - out_imem_req=1 in the first cycle after reset deassertion; 0 while in_rst=0.
  - out_imem_addr=RESET_PC, out_inst=0, out_pc=RESET_PC.
  - out_cycle_cnt=4'hF, out_inst_done=0.
  - redirect_pending=0, redirect_target=0.
- FETCH -> EXEC when out_imem_req & in_imem_ack. On that edge:
  - out_inst <= in_imem_rdata, out_pc <= pc.
  - out_cycle_cnt <= 0, out_imem_req <= 0.
- EXEC counting:
  - If in_stall=1, out_cycle_cnt holds.
  - Otherwise, when out_cycle_cnt < INST_CYCLES-1, out_cycle_cnt increments.
- EXEC -> FETCH when out_cycle_cnt==INST_CYCLES-1 and in_stall=0.
  - out_inst_done=1 in that cycle (combinational from state, count and stall).
  - Next pc = redirect target if a redirect is pending or in_redirect=1 this cycle; otherwise pc+4.
  - Next pc is registered into pc and out_imem_addr; out_imem_req <= 1; out_cycle_cnt <= 4'hF; redirect_pending cleared.
- Redirect capture (EXEC only):
  - In_redirect=1 sets redirect_pending and stores in_redirect_pc with bits [1:0] forced to 00.
  - A later redirect within the same instruction overwrites the earlier one; the last one wins.
  - In_redirect in FETCH is ignored.
- Arithmetic: pc+4 is 32-bit and wraps modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
- out_inst and out_pc are stable for the whole EXEC period, including stalls.

## Timing
- Zero-wait memory, where ack arrives in the first req cycle: one instruction every INST_CYCLES+1 cycles.
- Each memory wait cycle adds one cycle. Each stall cycle in EXEC adds one cycle.
- out_inst is valid in the cycle out_cycle_cnt first equals 0. The decoder registers it on the next edge.
- Ack asserted while out_imem_req=0 is ignored. in_imem_rdata is don't-care without ack.
- In_stall and in_redirect together on the last EXEC cycle: stall wins, no transition. The redirect is captured and applied when the stall releases.
- In_redirect on the last EXEC cycle without stall applies directly to the next fetch address.
- Reset asserted mid-operation:
  - All state clears immediately (asynchronous); out_imem_req drops without waiting for ack.
  - After release, fetch restarts at RESET_PC.
  - A late ack from the aborted request that arrives while out_imem_req=0 is ignored.

## Test plan
- Reset release, INST_CYCLES=4, ack with rdata 32'h00500093 in the first req cycle:
  - out_imem_addr=0.
  - Next cycle out_inst=32'h00500093, out_pc=0, out_cycle_cnt=0,1,2,3.
  - out_inst_done on cnt=3, then req with addr=4.
  - Period 5 cycles.
- Ack delayed 3 cycles: req held high with addr stable for 3 cycles; out_cycle_cnt=4'hF throughout; period 8 cycles.
- in_stall high 2 cycles at cnt=1:
  - cnt sequence 0,1,1,1,2,3; out_inst unchanged.
  - Next fetch at pc+4 after 7 cycles.
- in_redirect at cnt=1 with target 32'h0000_0102, then again at cnt=2 with 32'h0000_0200: next out_imem_addr=32'h0000_0200 (last wins; the first target would have aligned to 32'h0000_0100).
- pc=32'hFFFF_FFFC, no redirect: next out_imem_addr=32'h0000_0000.
- in_rst pulled low during the FETCH wait:
  - req=0 and cnt=4'hF immediately.
  - An ack given the following cycle is ignored.
  - After release, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/switch_mcu_fetch.sv
// rtl/switch_mcu_fetch.sv - instruction fetch/sequencing stage: PC, imem req/ack fetch,
// per-instruction execute cycle counter, redirect capture and stall hold.
module switch_mcu_fetch #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned INST_CYCLES = 4
) (
  input  logic        in_clk,
  input  logic        in_rst,
  output logic        out_imem_req,
  output logic [31:0] out_imem_addr,
  input  logic        in_imem_ack,
  input  logic [31:0] in_imem_rdata,
  input  logic        in_stall,
  input  logic        in_redirect,
  input  logic [31:0] in_redirect_pc,
  output logic [31:0] out_inst,
  output logic [31:0] out_pc,
  output logic [3:0]  out_cycle_cnt,
  output logic        out_inst_done
);

  localparam logic [3:0] LAST_CNT  = 4'(INST_CYCLES - 1);
  localparam logic [3:0] FETCH_CNT = 4'hF;

  typedef enum logic {S_FETCH, S_EXEC} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        req_q, req_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] inst_pc_q, inst_pc_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        pend_q, pend_d;
  logic [31:0] tgt_q, tgt_d;
  logic [31:0] redir_aligned;
  logic        done;

  assign redir_aligned = {in_redirect_pc[31:2], 2'b00};

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    req_d     = req_q;
    inst_d    = inst_q;
    inst_pc_d = inst_pc_q;
    cnt_d     = cnt_q;
    pend_d    = pend_q;
    tgt_d     = tgt_q;
    done      = 1'b0;
    case (state_q)
      S_FETCH: begin
        if (req_q && in_imem_ack) begin
          state_d   = S_EXEC;
          inst_d    = in_imem_rdata;
          inst_pc_d = pc_q;
          cnt_d     = 4'h0;
          req_d     = 1'b0;
        end
      end
      S_EXEC: begin
        // Captured even when stalled so a redirect on a held last cycle is not lost.
        if (in_redirect) begin
          pend_d = 1'b1;
          tgt_d  = redir_aligned;
        end
        if (!in_stall) begin
          if (cnt_q == LAST_CNT) begin
            done    = 1'b1;
            state_d = S_FETCH;
            if (in_redirect)  pc_d = redir_aligned;
            else if (pend_q)  pc_d = tgt_q;
            else              pc_d = pc_q + 32'd4;
            req_d  = 1'b1;
            cnt_d  = FETCH_CNT;
            pend_d = 1'b0;
          end else begin
            cnt_d = cnt_q + 4'h1;
          end
        end
      end
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge in_clk or negedge in_rst) begin
    if (!in_rst) begin
      state_q   <= S_FETCH;
      pc_q      <= RESET_PC;
      req_q     <= 1'b1;
      inst_q    <= 32'h0;
      inst_pc_q <= RESET_PC;
      cnt_q     <= FETCH_CNT;
      pend_q    <= 1'b0;
      tgt_q     <= 32'h0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      req_q     <= req_d;
      inst_q    <= inst_d;
      inst_pc_q <= inst_pc_d;
      cnt_q     <= cnt_d;
      pend_q    <= pend_d;
      tgt_q     <= tgt_d;
    end
  end

  // The request register resets to 1 so fetch starts the first cycle after release;
  // gating with reset keeps the request low while reset is held.
  assign out_imem_req  = req_q & in_rst;
  assign out_imem_addr = pc_q;
  assign out_inst      = inst_q;
  assign out_pc        = inst_pc_q;
  assign out_cycle_cnt = cnt_q;
  assign out_inst_done = done;

endmodule

// File: tb/tb_switch_mcu_fetch.sv
// tb/tb_switch_mcu_fetch.sv - table-driven per-cycle bench for switch_mcu_fetch.
module tb_switch_mcu_fetch;

  logic        in_clk;
  logic        in_rst;
  logic        out_imem_req;
  logic [31:0] out_imem_addr;
  logic        in_imem_ack;
  logic [31:0] in_imem_rdata;
  logic        in_stall;
  logic        in_redirect;
  logic [31:0] in_redirect_pc;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic [3:0]  out_cycle_cnt;
  logic        out_inst_done;

  switch_mcu_fetch #(.RESET_PC(32'h0000_0000), .INST_CYCLES(4)) dut (
    .in_clk         (in_clk),
    .in_rst         (in_rst),
    .out_imem_req   (out_imem_req),
    .out_imem_addr  (out_imem_addr),
    .in_imem_ack    (in_imem_ack),
    .in_imem_rdata  (in_imem_rdata),
    .in_stall       (in_stall),
    .in_redirect    (in_redirect),
    .in_redirect_pc (in_redirect_pc),
    .out_inst       (out_inst),
    .out_pc         (out_pc),
    .out_cycle_cnt  (out_cycle_cnt),
    .out_inst_done  (out_inst_done)
  );

  initial in_clk = 1'b0;
  always #5 in_clk = ~in_clk;

  typedef struct {
    logic        ack;
    logic [31:0] rdata;
    logic        stall;
    logic        redir;
    logic [31:0] rpc;
    logic        e_req;
    logic [31:0] e_addr;
    logic [3:0]  e_cnt;
    logic        e_done;
    logic [31:0] e_inst;
    logic [31:0] e_pc;
  } vec_t;

  vec_t vecs[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  localparam logic [31:0] I1 = 32'h0050_0093;
  localparam logic [31:0] I2 = 32'h1111_1111;
  localparam logic [31:0] I3 = 32'h2222_2222;
  localparam logic [31:0] I4 = 32'h3333_3333;
  localparam logic [31:0] I5 = 32'h4444_4444;
  localparam logic [31:0] I6 = 32'h5555_5555;

  task automatic add(input logic ack, input logic [31:0] rdata, input logic stall,
                     input logic redir, input logic [31:0] rpc, input logic e_req,
                     input logic [31:0] e_addr, input logic [3:0] e_cnt, input logic e_done,
                     input logic [31:0] e_inst, input logic [31:0] e_pc);
    vec_t v;
    v.ack = ack; v.rdata = rdata; v.stall = stall; v.redir = redir; v.rpc = rpc;
    v.e_req = e_req; v.e_addr = e_addr; v.e_cnt = e_cnt; v.e_done = e_done;
    v.e_inst = e_inst; v.e_pc = e_pc;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic chk_all(input int idx, input logic e_req, input logic [31:0] e_addr,
                         input logic [3:0] e_cnt, input logic e_done,
                         input logic [31:0] e_inst, input logic [31:0] e_pc);
    chk("req",  idx, {31'h0, out_imem_req},  {31'h0, e_req});
    chk("addr", idx, out_imem_addr,          e_addr);
    chk("cnt",  idx, {28'h0, out_cycle_cnt}, {28'h0, e_cnt});
    chk("done", idx, {31'h0, out_inst_done}, {31'h0, e_done});
    chk("inst", idx, out_inst,               e_inst);
    chk("pc",   idx, out_pc,                 e_pc);
  endtask

  initial begin
    // ack rdata stall redir rpc | req addr cnt done inst pc
    add(1, I1, 0, 0, 0,            1, 32'h0,   4'hF, 0, 32'h0, 32'h0);
    add(0, 0,  0, 0, 0,            0, 32'h0,   4'h0, 0, I1, 32'h0);
    add(0, 0,  0, 0, 0,            0, 32'h0,   4'h1, 0, I1, 32'h0);
    add(0, 0,  0, 0, 0,            0, 32'h0,   4'h2, 0, I1, 32'h0);
    add(0, 0,  0, 0, 0,            0, 32'h0,   4'h3, 1, I1, 32'h0);
    add(0, 0,  0, 0, 0,            1, 32'h4,   4'hF, 0, I1, 32'h0);
    add(0, 0,  0, 0, 0,            1, 32'h4,   4'hF, 0, I1, 32'h0);
    add(0, 0,  0, 0, 0,            1, 32'h4,   4'hF, 0, I1, 32'h0);
    add(1, I2, 0, 0, 0,            1, 32'h4,   4'hF, 0, I1, 32'h0);
    add(0, 0,  0, 0, 0,            0, 32'h4,   4'h0, 0, I2, 32'h4);
    add(0, 0,  1, 0, 0,            0, 32'h4,   4'h1, 0, I2, 32'h4);
    add(0, 0,  1, 0, 0,            0, 32'h4,   4'h1, 0, I2, 32'h4);
    add(0, 0,  0, 0, 0,            0, 32'h4,   4'h1, 0, I2, 32'h4);
    add(1, 32'hBADB_ADBA, 0, 0, 0, 0, 32'h4,   4'h2, 0, I2, 32'h4);
    add(0, 0,  0, 0, 0,            0, 32'h4,   4'h3, 1, I2, 32'h4);
    add(1, I3, 0, 1, 32'h400,      1, 32'h8,   4'hF, 0, I2, 32'h4);
    add(0, 0,  0, 0, 0,            0, 32'h8,   4'h0, 0, I3, 32'h8);
    add(0, 0,  0, 1, 32'h102,      0, 32'h8,   4'h1, 0, I3, 32'h8);
    add(0, 0,  0, 1, 32'h200,      0, 32'h8,   4'h2, 0, I3, 32'h8);
    add(0, 0,  0, 0, 0,            0, 32'h8,   4'h3, 1, I3, 32'h8);
    add(1, I4, 0, 0, 0,            1, 32'h200, 4'hF, 0, I3, 32'h8);
    add(0, 0,  0, 0, 0,            0, 32'h200, 4'h0, 0, I4, 32'h200);
    add(0, 0,  0, 0, 0,            0, 32'h200, 4'h1, 0, I4, 32'h200);
    add(0, 0,  0, 0, 0,            0, 32'h200, 4'h2, 0, I4, 32'h200);
    add(0, 0,  1, 1, 32'hFFFF_FFFF, 0, 32'h200, 4'h3, 0, I4, 32'h200);
    add(0, 0,  0, 0, 0,            0, 32'h200, 4'h3, 1, I4, 32'h200);
    add(1, I5, 0, 0, 0,            1, 32'hFFFF_FFFC, 4'hF, 0, I4, 32'h200);
    add(0, 0,  0, 0, 0,            0, 32'hFFFF_FFFC, 4'h0, 0, I5, 32'hFFFF_FFFC);
    add(0, 0,  0, 0, 0,            0, 32'hFFFF_FFFC, 4'h1, 0, I5, 32'hFFFF_FFFC);
    add(0, 0,  0, 0, 0,            0, 32'hFFFF_FFFC, 4'h2, 0, I5, 32'hFFFF_FFFC);
    add(0, 0,  0, 0, 0,            0, 32'hFFFF_FFFC, 4'h3, 1, I5, 32'hFFFF_FFFC);
    add(1, I6, 0, 0, 0,            1, 32'h0,   4'hF, 0, I5, 32'hFFFF_FFFC);
    add(0, 0,  0, 0, 0,            0, 32'h0,   4'h0, 0, I6, 32'h0);
    add(0, 0,  0, 0, 0,            0, 32'h0,   4'h1, 0, I6, 32'h0);
    add(0, 0,  0, 0, 0,            0, 32'h0,   4'h2, 0, I6, 32'h0);
    add(0, 0,  0, 0, 0,            0, 32'h0,   4'h3, 1, I6, 32'h0);
    add(0, 0,  0, 0, 0,            1, 32'h4,   4'hF, 0, I6, 32'h0);

    in_rst = 1'b0; in_imem_ack = 1'b0; in_imem_rdata = 32'h0;
    in_stall = 1'b0; in_redirect = 1'b0; in_redirect_pc = 32'h0;
    @(negedge in_clk); #1;
    chk_all(-1, 0, 32'h0, 4'hF, 0, 32'h0, 32'h0);

    @(negedge in_clk);
    in_rst = 1'b1;
    foreach (vecs[i]) begin
      if (i != 0) @(negedge in_clk);
      in_imem_ack    = vecs[i].ack;
      in_imem_rdata  = vecs[i].rdata;
      in_stall       = vecs[i].stall;
      in_redirect    = vecs[i].redir;
      in_redirect_pc = vecs[i].rpc;
      #1;
      chk_all(i, vecs[i].e_req, vecs[i].e_addr, vecs[i].e_cnt, vecs[i].e_done,
              vecs[i].e_inst, vecs[i].e_pc);
    end

    // Reset mid fetch wait (addr 4): request drops at once, late ack ignored.
    @(negedge in_clk);
    in_imem_ack = 1'b0; in_stall = 1'b0; in_redirect = 1'b0;
    #2;
    in_rst = 1'b0;
    #1;
    chk_all(100, 0, 32'h0, 4'hF, 0, 32'h0, 32'h0);
    @(negedge in_clk);
    in_imem_ack = 1'b1; in_imem_rdata = 32'hDEAD_BEEF;
    #1;
    chk_all(101, 0, 32'h0, 4'hF, 0, 32'h0, 32'h0);
    @(negedge in_clk);
    in_rst = 1'b1; in_imem_ack = 1'b0;
    #1;
    chk_all(102, 1, 32'h0, 4'hF, 0, 32'h0, 32'h0);
    @(negedge in_clk);
    in_imem_ack = 1'b1; in_imem_rdata = 32'h6666_6666;
    #1;
    chk_all(103, 1, 32'h0, 4'hF, 0, 32'h0, 32'h0);
    @(negedge in_clk);
    in_imem_ack = 1'b0;
    #1;
    chk_all(104, 0, 32'h0, 4'h0, 0, 32'h6666_6666, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
